pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: issues fetch requests with a valid/ready handshake.
// Redirects are handled here, and one redirect can be buffered while a request is stalled.
module pc_fetch_unit #(
    parameter int unsigned             Reg_size     = 32,
    parameter logic [Reg_size-1:0]     RESET_VECTOR = '0,
    parameter int unsigned             INC          = 4,
    parameter int unsigned             ALIGN_BITS   = 2,
    parameter int unsigned             CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                redirect_valid,
    input  logic [Reg_size-1:0] redirect_target,
    output logic                req_valid,
    output logic [Reg_size-1:0] req_addr,
    input  logic                req_ready,
    output logic [Reg_size-1:0] pc_out,
    output logic                err,
    output logic [Reg_size-1:0] err_addr,
    output logic [CNT_W-1:0]    fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERROR = 2'd2
    } state_t;

    // A zero-width alignment field yields an all-zero mask, so the check disappears.
    localparam logic [Reg_size-1:0] ALIGN_MASK = Reg_size'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t              state_q, state_d;
    logic [Reg_size-1:0] pc_q, pc_d;
    logic [Reg_size-1:0] pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [Reg_size-1:0] err_addr_q, err_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [Reg_size-1:0] tgt;
    logic                tgt_is_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        err_addr_d  = err_addr_q;
        cnt_d       = cnt_q;
        tgt         = pc_q + Reg_size'(INC);
        tgt_is_jump = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pend_vld_d = 1'b0;
                    if ((redirect_target & ALIGN_MASK) != '0) begin
                        state_d    = ERROR;
                        err_addr_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                        if (en) state_d = FETCH;
                    end
                end else if (en) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (req_ready) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    pend_vld_d = 1'b0;
                    if (redirect_valid) begin
                        tgt         = redirect_target;
                        tgt_is_jump = 1'b1;
                    end else if (pend_vld_q) begin
                        tgt         = pend_q;
                        tgt_is_jump = 1'b1;
                    end
                    if (tgt_is_jump && ((tgt & ALIGN_MASK) != '0)) begin
                        state_d    = ERROR;
                        err_addr_d = tgt;
                    end else begin
                        pc_d    = tgt;
                        state_d = en ? FETCH : IDLE;
                    end
                end else if (redirect_valid) begin
                    // Stalled request keeps its address; only the newest redirect is kept.
                    pend_d     = redirect_target;
                    pend_vld_d = 1'b1;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_valid   = (state_q == FETCH);
    assign req_addr    = pc_q;
    assign pc_out      = pc_q;
    assign err         = (state_q == ERROR);
    assign err_addr    = err_addr_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit; expected values are hand-computed per cycle.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic [31:0] pc_out;
    logic        err;
    logic [31:0] err_addr;
    logic [3:0]  fetch_count;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    pc_fetch_unit #(
        .Reg_size(32),
        .RESET_VECTOR(32'h0),
        .INC(4),
        .ALIGN_BITS(2),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .pc_out(pc_out),
        .err(err),
        .err_addr(err_addr),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rv;
        logic [31:0] rt;
        logic        rdy;
        logic        ev;
        logic [31:0] ea;
        logic        ee;
        logic [31:0] eea;
        logic [3:0]  ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic rv, input logic [31:0] rt,
                       input logic rdy, input logic ev, input logic [31:0] ea,
                       input logic ee, input logic [31:0] eea, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.en = e; v.rv = rv; v.rt = rt; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ee = ee; v.eea = eea; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string tag, input logic ev, input logic [31:0] ea,
                         input logic ee, input logic [31:0] eea, input logic [3:0] ec);
        n_vec++;
        if (req_valid !== ev) begin
            n_miss++;
            $display("FAIL %s req_valid: got %0b want %0b", tag, req_valid, ev);
        end
        if (req_addr !== ea) begin
            n_miss++;
            $display("FAIL %s req_addr: got %08h want %08h", tag, req_addr, ea);
        end
        if (pc_out !== ea) begin
            n_miss++;
            $display("FAIL %s pc_out: got %08h want %08h", tag, pc_out, ea);
        end
        if (err !== ee) begin
            n_miss++;
            $display("FAIL %s err: got %0b want %0b", tag, err, ee);
        end
        if (err_addr !== eea) begin
            n_miss++;
            $display("FAIL %s err_addr: got %08h want %08h", tag, err_addr, eea);
        end
        if (fetch_count !== ec) begin
            n_miss++;
            $display("FAIL %s fetch_count: got %0d want %0d", tag, fetch_count, ec);
        end
    endtask

    initial begin
        //   rst en rv target        rdy | v  addr          err erraddr   cnt
        add(1, 0, 0, 32'h0,         0,   0, 32'h0,        0, 32'h0,   4'd0);
        add(0, 1, 0, 32'h0,         1,   1, 32'h0,        0, 32'h0,   4'd0);
        add(0, 1, 0, 32'h0,         1,   1, 32'h4,        0, 32'h0,   4'd1);
        add(0, 1, 0, 32'h0,         1,   1, 32'h8,        0, 32'h0,   4'd2);
        add(0, 0, 0, 32'h0,         0,   1, 32'h8,        0, 32'h0,   4'd2);
        add(0, 1, 0, 32'h0,         0,   1, 32'h8,        0, 32'h0,   4'd2);
        add(0, 0, 0, 32'h0,         0,   1, 32'h8,        0, 32'h0,   4'd2);
        add(0, 1, 0, 32'h0,         1,   1, 32'hC,        0, 32'h0,   4'd3);
        add(0, 1, 0, 32'h0,         1,   1, 32'h10,       0, 32'h0,   4'd4);
        add(0, 1, 1, 32'h100,       0,   1, 32'h10,       0, 32'h0,   4'd4);
        add(0, 1, 1, 32'h200,       0,   1, 32'h10,       0, 32'h0,   4'd4);
        add(0, 1, 0, 32'h0,         1,   1, 32'h200,      0, 32'h0,   4'd5);
        add(0, 1, 0, 32'h0,         1,   1, 32'h204,      0, 32'h0,   4'd6);
        add(0, 0, 0, 32'h0,         1,   0, 32'h208,      0, 32'h0,   4'd7);
        add(0, 0, 1, 32'hFFFFFFFC,  0,   0, 32'hFFFFFFFC, 0, 32'h0,   4'd7);
        add(0, 1, 0, 32'h0,         0,   1, 32'hFFFFFFFC, 0, 32'h0,   4'd7);
        add(0, 1, 0, 32'h0,         1,   1, 32'h0,        0, 32'h0,   4'd8);
        add(0, 1, 1, 32'h40,        1,   1, 32'h40,       0, 32'h0,   4'd9);
        add(0, 1, 1, 32'h80,        0,   1, 32'h40,       0, 32'h0,   4'd9);
        add(0, 1, 1, 32'hC0,        1,   1, 32'hC0,       0, 32'h0,   4'd10);
        add(0, 1, 0, 32'h0,         1,   1, 32'hC4,       0, 32'h0,   4'd11);
        add(0, 1, 0, 32'h0,         1,   1, 32'hC8,       0, 32'h0,   4'd12);
        add(0, 1, 0, 32'h0,         1,   1, 32'hCC,       0, 32'h0,   4'd13);
        add(0, 1, 0, 32'h0,         1,   1, 32'hD0,       0, 32'h0,   4'd14);
        add(0, 1, 0, 32'h0,         1,   1, 32'hD4,       0, 32'h0,   4'd15);
        add(0, 1, 0, 32'h0,         1,   1, 32'hD8,       0, 32'h0,   4'd0);
        add(0, 1, 1, 32'h102,       1,   0, 32'hD8,       1, 32'h102, 4'd1);
        add(0, 1, 1, 32'h300,       1,   0, 32'hD8,       1, 32'h102, 4'd1);
        add(1, 1, 0, 32'h0,         1,   0, 32'h0,        0, 32'h0,   4'd0);
        add(0, 1, 0, 32'h0,         1,   1, 32'h0,        0, 32'h0,   4'd0);
        add(0, 1, 1, 32'h101,       0,   1, 32'h0,        0, 32'h0,   4'd0);
        add(0, 1, 1, 32'h20,        0,   1, 32'h0,        0, 32'h0,   4'd0);
        add(0, 1, 0, 32'h0,         1,   1, 32'h20,       0, 32'h0,   4'd1);
        add(0, 0, 0, 32'h0,         1,   0, 32'h24,       0, 32'h0,   4'd2);
        add(0, 0, 1, 32'h6,         0,   0, 32'h24,       1, 32'h6,   4'd2);
        add(0, 1, 0, 32'h0,         1,   0, 32'h24,       1, 32'h6,   4'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            en              = vecs[i].en;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].rt;
            req_ready       = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].ee, vecs[i].eea, vecs[i].ec);
        end

        // Asynchronous reset arriving mid-request, between clock edges.
        @(negedge clk);
        rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        check("arst_setup0", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0);
        @(negedge clk);
        req_ready = 1'b1;
        @(posedge clk); #1;
        check("arst_setup1", 1'b1, 32'h4, 1'b0, 32'h0, 4'd1);
        @(negedge clk);
        req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_midcycle", 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        req_ready = 1'b1;
        @(posedge clk); #1;
        check("arst_held", 1'b0, 32'h0, 1'b0, 32'h0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_first_req", 1'b1, 32'h0, 1'b0, 32'h0, 4'd0);
        @(posedge clk); #1;
        check("arst_second_req", 1'b1, 32'h4, 1'b0, 32'h0, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
